// File: rtl/nibble_sorter_pkg.sv
// Shared types and sizing helpers for the nibble frame sorter.
package nibble_sorter_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } sort_state_t;

    localparam int N_MIN = 2;
    localparam int N_MAX = 8;

    // Width of an index into an N-entry frame; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_compare.sv
// Unsigned W-bit magnitude comparator shared by every bubble-sort step.
module nibble_compare #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         lt,
    output logic         gt
);

    always_comb begin
        eq = (a == b);
        lt = (a < b);
        gt = (a > b);
    end

endmodule

// File: rtl/nibble_sorter.sv
// Collects N words, bubble-sorts them in place with one comparator per cycle,
// then streams the sorted frame out over a valid/ready handshake.
module nibble_sorter
    import nibble_sorter_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         descending,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

    localparam int IW = idx_width(N);

    sort_state_t   state;
    sort_state_t   state_nx;
    logic [W-1:0]  mem [N];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] j;
    logic [IW-1:0] j_nx;
    logic [IW-1:0] pass;
    logic          swapped;
    logic          mode;
    logic          done_r;

    logic          accept;
    logic          handshake;
    logic          last_wr;
    logic          last_rd;
    logic          last_j;
    logic          last_pass;
    logic          sort_exit;
    logic [W-1:0]  word_a;
    logic [W-1:0]  word_b;
    logic          cmp_eq;
    logic          cmp_lt;
    logic          cmp_gt;
    logic          swap;

    assign accept    = in_valid && (state == LOAD);
    assign handshake = out_ready && (state == DRAIN);
    assign last_wr   = (wr_idx == IW'(N - 1));
    assign last_rd   = (rd_idx == IW'(N - 1));
    assign j_nx      = j + IW'(1);
    assign last_j    = (j == (IW'(N - 2) - pass));
    assign last_pass = (pass == IW'(N - 2));
    assign word_a    = mem[j];
    assign word_b    = mem[j_nx];

    nibble_compare #(.W(W)) u_cmp (
        .a  (word_a),
        .b  (word_b),
        .eq (cmp_eq),
        .lt (cmp_lt),
        .gt (cmp_gt)
    );

    // Unequal words: gt for ascending, flipped to lt by the mode bit; equal words never move.
    assign swap      = !cmp_eq && (cmp_gt ^ mode);
    assign sort_exit = last_j && (!(swapped || swap) || last_pass);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (accept && last_wr)    state_nx = SORT;
            SORT:    if (sort_exit)            state_nx = DRAIN;
            DRAIN:   if (handshake && last_rd) state_nx = LOAD;
            default:                           state_nx = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == DRAIN);
        busy      = (state != LOAD);
        out_data  = (state == DRAIN) ? mem[rd_idx] : '0;
        done      = done_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
            wr_idx  <= '0;
            rd_idx  <= '0;
            j       <= '0;
            pass    <= '0;
            swapped <= 1'b0;
            mode    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        mem[wr_idx] <= in_data;
                        if (wr_idx == '0) mode <= descending;
                        if (last_wr) begin
                            wr_idx  <= '0;
                            pass    <= '0;
                            j       <= '0;
                            swapped <= 1'b0;
                        end else begin
                            wr_idx <= wr_idx + IW'(1);
                        end
                    end
                end
                SORT: begin
                    if (swap) begin
                        mem[j]    <= word_b;
                        mem[j_nx] <= word_a;
                    end
                    if (last_j) begin
                        if (!sort_exit) pass <= pass + IW'(1);
                        j       <= '0;
                        swapped <= 1'b0;
                    end else begin
                        j       <= j_nx;
                        swapped <= swapped || swap;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        if (last_rd) begin
                            rd_idx <= '0;
                            done_r <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_sorter.sv
// Randomised and directed bench for nibble_sorter (N=4, W=4) against a counting-sort model.
module tb_nibble_sorter;

    localparam int N = 4;
    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         descending;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    nibble_sorter #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .descending (descending),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stable sort by value: emit each key in order, words of equal key in arrival order.
    task automatic model_sort(input logic [W-1:0] w [N], input bit desc, output logic [W-1:0] e [N]);
        int k;
        k = 0;
        for (int v = 0; v < 16; v++) begin
            int key;
            key = desc ? 15 - v : v;
            for (int i = 0; i < N; i++)
                if (int'(w[i]) == key) begin
                    e[k] = w[i];
                    k++;
                end
        end
    endtask

    task automatic load_frame(input logic [W-1:0] w [N], input bit desc, input bit toggle, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            int guard;
            bit acc;
            guard      = 0;
            in_valid   = 1'b1;
            in_data    = w[i];
            descending = (i == 0 || !toggle) ? desc : ~desc;
            do begin
                acc = in_ready;
                step();
                guard++;
            end while (!acc && guard < 20);
            if (!acc) ok = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_sort(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 50) begin
            cycles++;
            step();
        end
    endtask

    task automatic drain_frame(input int max_stall, output logic [W-1:0] got [N], output int early_done, output bit ok);
        ok = 1'b1;
        early_done = 0;
        for (int i = 0; i < N; i++) begin
            int guard;
            int k;
            k = $urandom_range(0, max_stall);
            out_ready = 1'b0;
            for (int s = 0; s < k; s++) step();
            guard = 0;
            while (!out_valid && guard < 50) begin
                step();
                guard++;
            end
            if (!out_valid) ok = 1'b0;
            got[i] = out_data;
            if (done) early_done++;
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_tests++; if (out_data !== 4'h0)  begin n_fail++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        rst_n = 1'b1;
        step();
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
    endtask

    // One full frame with known sort length; checks outputs, done timing and return to LOAD.
    task automatic run_directed(input string name, input logic [W-1:0] w [N], input bit desc, input bit toggle, input int want_cycles);
        logic [W-1:0] exp_q [N];
        logic [W-1:0] got [N];
        bit ok;
        int cyc;
        int early;
        model_sort(w, desc, exp_q);
        load_frame(w, desc, toggle, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL %s_load got=timeout want=accepted", name); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_sort got=%b want=1", name, busy); end
        wait_sort(cyc);
        if (want_cycles > 0) begin
            n_tests++; if (cyc != want_cycles) begin n_fail++; $display("FAIL %s_sort_len got=%0d want=%0d", name, cyc, want_cycles); end
        end
        drain_frame(0, got, early, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL %s_drain got=timeout want=out_valid", name); end
        for (int i = 0; i < N; i++) begin
            n_tests++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL %s_out%0d got=%h want=%h", name, i, got[i], exp_q[i]); end
        end
        n_tests++; if (early != 0) begin n_fail++; $display("FAIL %s_done_early got=%0d want=0", name, early); end
        n_tests++; if (done !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_done_pulse got=done%b/ready%b want=1/1", name, done, in_ready); end
        step();
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_width got=%b want=0", name, done); end
    endtask

    task automatic test_ascending();
        logic [W-1:0] w1 [N] = '{4'h9, 4'h3, 4'hF, 4'h0};
        logic [W-1:0] w2 [N] = '{4'h1, 4'h2, 4'h3, 4'h4};
        run_directed("asc_unsorted", w1, 1'b0, 1'b0, 6);
        run_directed("asc_sorted", w2, 1'b0, 1'b0, 3);
    endtask

    task automatic test_descending_dup();
        logic [W-1:0] w [N] = '{4'h5, 4'hA, 4'h5, 4'h0};
        run_directed("desc_dup", w, 1'b1, 1'b1, 0);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] w [N] = '{4'h7, 4'h2, 4'hE, 4'h4};
        logic [W-1:0] want [N] = '{4'h2, 4'h4, 4'h7, 4'hE};
        logic [W-1:0] got [N];
        bit ok;
        int cyc;
        int early;
        load_frame(w, 1'b0, 1'b0, ok);
        wait_sort(cyc);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            n_tests++; if (out_valid !== 1'b1 || out_data !== 4'h2) begin n_fail++; $display("FAIL bp_hold%0d got=v%b/%h want=v1/2", s, out_valid, out_data); end
            step();
        end
        drain_frame(0, got, early, ok);
        for (int i = 0; i < N; i++) begin
            n_tests++; if (got[i] !== want[i]) begin n_fail++; $display("FAIL bp_out%0d got=%h want=%h", i, got[i], want[i]); end
        end
    endtask

    task automatic test_ignore_input();
        logic [W-1:0] w [N] = '{4'hC, 4'h1, 4'h8, 4'h6};
        logic [W-1:0] want [N] = '{4'h1, 4'h6, 4'h8, 4'hC};
        logic [W-1:0] got [N];
        bit ok;
        int guard;
        int bad_ready;
        load_frame(w, 1'b0, 1'b0, ok);
        in_valid  = 1'b1;
        bad_ready = 0;
        guard     = 0;
        while (!out_valid && guard < 50) begin
            if (in_ready !== 1'b0) bad_ready++;
            in_data = 4'($urandom);
            step();
            guard++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (in_ready !== 1'b0) bad_ready++;
            got[i] = out_data;
            in_data = 4'($urandom);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_tests++; if (bad_ready != 0) begin n_fail++; $display("FAIL ignore_in_ready got=%0d_high_cycles want=0", bad_ready); end
        for (int i = 0; i < N; i++) begin
            n_tests++; if (got[i] !== want[i]) begin n_fail++; $display("FAIL ignore_out%0d got=%h want=%h", i, got[i], want[i]); end
        end
        begin
            logic [W-1:0] w2 [N] = '{4'h3, 4'hB, 4'h0, 4'h7};
            run_directed("ignore_next", w2, 1'b1, 1'b0, 0);
        end
    endtask

    task automatic test_reset_mid_sort();
        logic [W-1:0] w [N] = '{4'h9, 4'h3, 4'hF, 4'h0};
        logic [W-1:0] w2 [N] = '{4'h3, 4'h1, 4'h2, 4'h0};
        bit ok;
        load_frame(w, 1'b0, 1'b0, ok);
        step();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midsort_reset got=r%b v%b d%h b%b dn%b want=r1 v0 d0 b0 dn0", in_ready, out_valid, out_data, busy, done);
        end
        step();
        rst_n = 1'b1;
        step();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midsort_release got=%b want=1", in_ready); end
        run_directed("after_reset", w2, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 25; f++) begin
            logic [W-1:0] w [N];
            logic [W-1:0] exp_q [N];
            logic [W-1:0] got [N];
            bit desc;
            bit ok;
            int cyc;
            int early;
            for (int i = 0; i < N; i++) w[i] = 4'($urandom_range(0, (f % 3 == 0) ? 3 : 15));
            desc = 1'($urandom);
            model_sort(w, desc, exp_q);
            load_frame(w, desc, 1'($urandom), ok);
            wait_sort(cyc);
            n_tests++; if (cyc < N - 1 || cyc > N * (N - 1) / 2) begin n_fail++; $display("FAIL rand%0d_sort_len got=%0d want=3..6", f, cyc); end
            drain_frame(2, got, early, ok);
            for (int i = 0; i < N; i++) begin
                n_tests++; if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_out%0d got=%h want=%h", f, i, got[i], exp_q[i]); end
            end
            n_tests++; if (done !== 1'b1 || early != 0) begin n_fail++; $display("FAIL rand%0d_done got=%b/%0d want=1/0", f, done, early); end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        descending = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_ascending();
        test_descending_dup();
        test_backpressure();
        test_ignore_input();
        test_reset_mid_sort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
